// File: rtl/vga_pkg.sv
// Shared timing defaults, sizing helpers and payload types for the VGA timing generator.
package vga_pkg;

  // Default 640x480@60 timing (pixels / lines)
  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_PIPE_DELAY = 0;
  localparam int unsigned DEF_COLOR_W    = 8;

  // Total period of a line or frame from its four segments.
  function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Per-pixel timing flags carried down the delay line.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_t;

  // RGB payload at the default channel width.
  typedef struct packed {
    logic [DEF_COLOR_W-1:0] red;
    logic [DEF_COLOR_W-1:0] green;
    logic [DEF_COLOR_W-1:0] blue;
  } rgb_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bus between the timing generator, the drawing logic and the video DAC.
interface vga_timing_gen_if import vga_pkg::*; #(
  parameter int unsigned COLOR_W = DEF_COLOR_W,
  parameter int unsigned H_W     = cnt_w(line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP)),
  parameter int unsigned V_W     = cnt_w(line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP))
) ();

  logic [3*COLOR_W-1:0] color_in;
  logic                 pixel_en;
  logic [H_W-1:0]       h_count;
  logic [V_W-1:0]       v_count;
  logic                 line_start;
  logic                 frame_start;
  logic                 vga_hs;
  logic                 vga_vs;
  logic                 vga_blank_n;
  logic                 vga_sync_n;
  logic [COLOR_W-1:0]   red;
  logic [COLOR_W-1:0]   green;
  logic [COLOR_W-1:0]   blue;

  modport master (
    input  color_in,
    output pixel_en, h_count, v_count, line_start, frame_start,
    output vga_hs, vga_vs, vga_blank_n, vga_sync_n, red, green, blue
  );

  modport slave (
    output color_in,
    input  pixel_en, h_count, v_count, line_start, frame_start,
    input  vga_hs, vga_vs, vga_blank_n, vga_sync_n, red, green, blue
  );

endinterface

// File: rtl/pixel_clk_en.sv
// Divides the system clock down to a one-clock pixel enable every CLK_DIV clocks.
module pixel_clk_en import vga_pkg::*; #(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_en,
  output logic pixel_en_next_c
);

  localparam int unsigned DIV_W = cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;

  // Next divider value and the enable it implies.
  always_comb begin
    div_next        = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    pixel_en_next_c = (div_next == DIV_LAST);
  end

  // Divider state; pixel_en is kept equal to (div_cnt == CLK_DIV-1) but held low in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      pixel_en <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      pixel_en <= pixel_en_next_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel divider, h/v counters, sync/blank
// decode delayed to match the application colour pipeline, and blanked RGB stage.
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY,
  parameter int unsigned COLOR_W    = DEF_COLOR_W
) (
  input logic            clk,
  input logic            reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned H_W      = cnt_w(H_TOTAL);
  localparam int unsigned V_W      = cnt_w(V_TOTAL);
  localparam int unsigned RGB_W    = 3 * COLOR_W;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  logic pixel_en;
  logic pixel_en_next_c;

  pixel_clk_en #(.CLK_DIV(CLK_DIV)) u_pixel_clk_en (
    .clk             (clk),
    .reset           (reset),
    .pixel_en        (pixel_en),
    .pixel_en_next_c (pixel_en_next_c)
  );

  logic [H_W-1:0] h_count, h_next;
  logic [V_W-1:0] v_count, v_next;
  logic           line_start, frame_start;

  // Counter advance: h on every pixel tick, v on the h wrap.
  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (pixel_en) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        v_next = (v_count == V_LAST) ? '0 : v_count + V_W'(1);
      end else begin
        h_next = h_count + H_W'(1);
      end
    end
  end

  // Counter registers; line/frame markers are registered so they coincide with pixel_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count     <= '0;
      v_count     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_count     <= h_next;
      v_count     <= v_next;
      line_start  <= pixel_en_next_c && (h_next == '0);
      frame_start <= pixel_en_next_c && (h_next == '0) && (v_next == '0);
    end
  end

  sync_t dec;

  // Region decode from the current counter position.
  always_comb begin
    dec        = '0;
    dec.active = (32'(h_count) < H_ACTIVE) && (32'(v_count) < V_ACTIVE);
    dec.hs     = (32'(h_count) >= HS_START) && (32'(h_count) < HS_END);
    dec.vs     = (32'(v_count) >= VS_START) && (32'(v_count) < VS_END);
  end

  // Delay line: stage_in[i] is what stage i loads on the next pixel tick.
  sync_t [PIPE_DELAY:0] pipe;
  sync_t [PIPE_DELAY:0] stage_in;

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign stage_in = dec;
  end else begin : g_delay
    assign stage_in = {pipe[PIPE_DELAY-1:0], dec};
  end

  // Shift the timing flags one stage per pixel tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else if (pixel_en) begin
      pipe <= stage_in;
    end
  end

  logic [RGB_W-1:0] rgb;

  // Colour register samples color_in on the tick its pixel reaches the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else if (pixel_en) begin
      rgb <= stage_in[PIPE_DELAY].active ? bus.color_in : '0;
    end
  end

  sync_t pipe_out;
  assign pipe_out = pipe[PIPE_DELAY];

  assign bus.pixel_en    = pixel_en;
  assign bus.h_count     = h_count;
  assign bus.v_count     = v_count;
  assign bus.line_start  = line_start;
  assign bus.frame_start = frame_start;
  assign bus.vga_hs      = pipe_out.hs ? HS_POL : ~HS_POL;
  assign bus.vga_vs      = pipe_out.vs ? VS_POL : ~VS_POL;
  assign bus.vga_blank_n = pipe_out.active;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.red         = rgb[RGB_W-1 -: COLOR_W];
  assign bus.green       = rgb[2*COLOR_W-1 -: COLOR_W];
  assign bus.blue        = rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-timing instances (div2/delay0, div2/delay3,
// div1/active-high sync) checked every clock against a timing model, plus a hand table.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_W(8), .H_W(4), .V_W(3)) bus_a ();
  vga_timing_gen_if #(.COLOR_W(8), .H_W(4), .V_W(3)) bus_b ();
  vga_timing_gen_if #(.COLOR_W(8), .H_W(4), .V_W(3)) bus_c ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .PIPE_DELAY(0), .COLOR_W(8)
  ) dut_a (.clk(clk), .reset(rst), .bus(bus_a.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .PIPE_DELAY(3), .COLOR_W(8)
  ) dut_b (.clk(clk), .reset(rst), .bus(bus_b.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .PIPE_DELAY(0), .COLOR_W(8)
  ) dut_c (.clk(clk), .reset(rst), .bus(bus_c.master));

  typedef struct packed {
    logic        pen;
    logic [3:0]  h;
    logic [2:0]  v;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
    logic [23:0] rgb;
  } obs_t;

  typedef struct {
    int         k;
    logic [3:0] h;
    logic [2:0] v;
    logic       pen;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       bn;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  obs_t oa, ob, oc;
  assign oa = {bus_a.pixel_en, bus_a.h_count, bus_a.v_count, bus_a.line_start, bus_a.frame_start,
               bus_a.vga_hs, bus_a.vga_vs, bus_a.vga_blank_n, bus_a.vga_sync_n,
               bus_a.red, bus_a.green, bus_a.blue};
  assign ob = {bus_b.pixel_en, bus_b.h_count, bus_b.v_count, bus_b.line_start, bus_b.frame_start,
               bus_b.vga_hs, bus_b.vga_vs, bus_b.vga_blank_n, bus_b.vga_sync_n,
               bus_b.red, bus_b.green, bus_b.blue};
  assign oc = {bus_c.pixel_en, bus_c.h_count, bus_c.v_count, bus_c.line_start, bus_c.frame_start,
               bus_c.vga_hs, bus_c.vga_vs, bus_c.vga_blank_n, bus_c.vga_sync_n,
               bus_c.red, bus_c.green, bus_c.blue};

  // Expected outputs k clocks after reset release.
  // cfg 0: div2/delay0/low sync, cfg 1: div2/delay3, cfg 2: div1/high sync.
  function automatic obs_t model(input int k, input int cfg);
    obs_t m;
    int   n, p, hp, vp;
    bit   act, hsa, vsa;
    m     = '0;
    n     = (cfg == 2) ? k - 1 : k / 2;
    m.pen = (cfg == 2) ? 1'b1 : ((k % 2) == 1);
    m.h   = 4'(n % 16);
    m.v   = 3'((n / 16) % 8);
    m.ls  = m.pen && (m.h == 4'd0);
    m.fs  = m.ls && (m.v == 3'd0);
    p     = n - ((cfg == 1) ? 4 : 1);
    hp    = 0;
    act   = 1'b0;
    hsa   = 1'b0;
    vsa   = 1'b0;
    if (p >= 0) begin
      hp  = p % 16;
      vp  = (p / 16) % 8;
      act = (hp < 8) && (vp < 4);
      hsa = (hp >= 10) && (hp <= 12);
      vsa = (vp >= 5) && (vp <= 6);
    end
    m.hs = (cfg == 2) ? hsa : !hsa;
    m.vs = (cfg == 2) ? vsa : !vsa;
    m.bn = act;
    m.sn = 1'b0;
    if (act) begin
      case (cfg)
        0:       m.rgb = 24'hFFFFFF;
        1:       m.rgb = {8'(hp), 8'h5A, 8'hC3};
        default: m.rgb = 24'h123456;
      endcase
    end
    return m;
  endfunction

  function automatic obs_t reset_exp(input int cfg);
    obs_t m;
    m    = '0;
    m.hs = (cfg != 2);
    m.vs = (cfg != 2);
    return m;
  endfunction

  task automatic cmp(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=0x%0h exp=0x%0h", name, k, got, exp);
    end
  endtask

  task automatic check_obs(input string tag, input int k, input obs_t got, input obs_t exp);
    cmp({tag, ".pixel_en"},    k, 32'(got.pen), 32'(exp.pen));
    cmp({tag, ".h_count"},     k, 32'(got.h),   32'(exp.h));
    cmp({tag, ".v_count"},     k, 32'(got.v),   32'(exp.v));
    cmp({tag, ".line_start"},  k, 32'(got.ls),  32'(exp.ls));
    cmp({tag, ".frame_start"}, k, 32'(got.fs),  32'(exp.fs));
    cmp({tag, ".vga_hs"},      k, 32'(got.hs),  32'(exp.hs));
    cmp({tag, ".vga_vs"},      k, 32'(got.vs),  32'(exp.vs));
    cmp({tag, ".blank_n"},     k, 32'(got.bn),  32'(exp.bn));
    cmp({tag, ".sync_n"},      k, 32'(got.sn),  32'(exp.sn));
    cmp({tag, ".rgb"},         k, 32'(got.rgb), 32'(exp.rgb));
  endtask

  // Run n clocks from reset release, checking every instance and any table entry due.
  task automatic run(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check_obs("a", k, oa, model(k, 0));
      check_obs("b", k, ob, model(k, 1));
      check_obs("c", k, oc, model(k, 2));
      for (int i = 0; i < NV; i++) begin
        if (tbl[i].k == k) begin
          cmp("tbl.h",   k, 32'(oa.h),   32'(tbl[i].h));
          cmp("tbl.v",   k, 32'(oa.v),   32'(tbl[i].v));
          cmp("tbl.pen", k, 32'(oa.pen), 32'(tbl[i].pen));
          cmp("tbl.ls",  k, 32'(oa.ls),  32'(tbl[i].ls));
          cmp("tbl.fs",  k, 32'(oa.fs),  32'(tbl[i].fs));
          cmp("tbl.hs",  k, 32'(oa.hs),  32'(tbl[i].hs));
          cmp("tbl.vs",  k, 32'(oa.vs),  32'(tbl[i].vs));
          cmp("tbl.bn",  k, 32'(oa.bn),  32'(tbl[i].bn));
        end
      end
    end
  endtask

  // One-clock reset pulse, then every output must be at its reset value.
  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    check_obs("a_rst", 0, oa, reset_exp(0));
    check_obs("b_rst", 0, ob, reset_exp(1));
    check_obs("c_rst", 0, oc, reset_exp(2));
    rst = 1'b0;
  endtask

  // Drawing-logic stand-in for instance b: red = h_count from three pixel ticks earlier.
  initial begin
    logic [7:0] d1, d2, d3;
    d1 = '0;
    d2 = '0;
    d3 = '0;
    bus_b.color_in = '0;
    forever begin
      @(negedge clk);
      if (bus_b.pixel_en) begin
        bus_b.color_in = {d3, 8'h5A, 8'hC3};
        d3 = d2;
        d2 = d1;
        d1 = 8'(bus_b.h_count);
      end
    end
  end

  initial begin
    //            k    h      v     pen  ls   fs   hs   vs   bn
    tbl[0]  = '{  1, 4'd0,  3'd0, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
    tbl[1]  = '{  2, 4'd1,  3'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[2]  = '{ 17, 4'd8,  3'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[3]  = '{ 18, 4'd9,  3'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[4]  = '{ 22, 4'd11, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[5]  = '{ 26, 4'd13, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[6]  = '{ 28, 4'd14, 3'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[7]  = '{ 33, 4'd0,  3'd1, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0};
    tbl[8]  = '{ 35, 4'd1,  3'd1, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[9]  = '{130, 4'd1,  3'd4, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[10] = '{162, 4'd1,  3'd5, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[11] = '{224, 4'd0,  3'd7, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[12] = '{226, 4'd1,  3'd7, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[13] = '{257, 4'd0,  3'd0, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};

    rst = 1'b1;
    bus_a.color_in = 24'hFFFFFF;
    bus_c.color_in = 24'h123456;
    @(negedge clk);
    reset_pulse();
    run(300);

    // Second pass stops mid-frame at h=5, v=2 on instance a and resets there.
    reset_pulse();
    run(74);
    cmp("a.h_before_reset", 74, 32'(oa.h), 32'd5);
    cmp("a.v_before_reset", 74, 32'(oa.v), 32'd2);
    reset_pulse();
    run(260);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
